pll_lock_supervisor: RTL and testbench
======================================

# pll_lock_supervisor

Sequences and supervises the pixel-clock PLL from the 50 MHz reference domain: pulses the PLL reset, waits for `locked`, qualifies it as stable, then releases the reset for the 74.25 MHz video pipeline. It detects lock loss and re-sequences the PLL automatically. It gives up after a bounded number of failed attempts and reports a fault to the control logic.

## Interface
- `PLL_RST_CYCLES`, default 16: number of cycles `pll_rst` is held high per attempt.
- `LOCK_TIMEOUT`, default 50000 (1 ms at 50 MHz): cycles allowed in WAIT_LOCK before the attempt fails.
- `STABLE_CYCLES`, default 1024: consecutive cycles of synchronised `locked`=1 required before release.
- `MAX_RETRIES`, default 3: failed attempts tolerated before FAULT.
- `refclk`  in  1  reference clock; 50 MHz; the only clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `locked`  in  1  PLL lock flag; asynchronous to `refclk`.
- `restart`  in  1  single-cycle request to re-sequence from scratch.
- `pll_rst`  out  1  active-high reset to the PLL.
- `sys_rst_n`  out  1  active-low reset for video-domain logic.
- `lock_ok`  out  1  high only in RUN.
- `fault`  out  1  high only in FAULT.
- `retry_count`  out  3  failed attempts in the current sequence.
- `unlock_count`  out  8  lock losses seen while in RUN; saturates at 255.

## Operation
- `locked` passes through a 2-flop synchroniser (`locked_s`). All decisions use `locked_s`.
- One shared timer, width `$clog2` of the largest parameter plus 1, is cleared on every state entry.
- States:
  - **RESET_PLL**: `pll_rst`=1. After PLL_RST_CYCLES cycles, go to WAIT_LOCK.
  - **WAIT_LOCK**: `pll_rst`=0.
    - `locked_s`=1: go to STABILIZE.
    - Timer reaches LOCK_TIMEOUT-1: increment `retry_count`. If the new value equals MAX_RETRIES, go to FAULT; otherwise go to RESET_PLL.
  - **STABILIZE**:
    - `locked_s`=0: go back to WAIT_LOCK. The timer restarts. `retry_count` is unchanged.
    - Timer reaches STABLE_CYCLES-1 with `locked_s` still 1: go to RUN.
  - **RUN**: `sys_rst_n`=1, `lock_ok`=1.
    - `locked_s`=0: increment `unlock_count` (saturating), clear `retry_count`, go to RESET_PLL.
  - **FAULT**: `pll_rst`=1, `fault`=1. Stays here until `restart`.
- `restart` in any state: go to RESET_PLL, clear `retry_count`, clear `fault`. `unlock_count` is kept.
- Simultaneous events:
  - `restart` has priority over every other transition.
  - A lock loss in the same cycle as `restart` does not increment `unlock_count`.
- `sys_rst_n` is 0 in every state except RUN.
- All outputs are registered, decoded from the next state.

## Timing
- Reset values: state RESET_PLL, `pll_rst`=1, `sys_rst_n`=0, `lock_ok`=0, `fault`=0, `retry_count`=0, `unlock_count`=0, timer 0.
- After `rst_n` deasserts, `pll_rst` stays high for exactly PLL_RST_CYCLES rising edges.
- `locked` rising to STABILIZE entry: 3 edges (2 synchroniser, 1 state).
- STABILIZE entry to `sys_rst_n`=1: STABLE_CYCLES edges.
- `locked` falling in RUN to `sys_rst_n`=0 and `pll_rst`=1: 3 edges.
- A `restart` pulse sampled at edge N gives `pll_rst`=1 after edge N.
- Asserting `rst_n` at any point forces the reset values immediately, without waiting for a clock edge.

## Structure
- The shared package `video_ctrl_pkg` holds:
  - the state enum `pll_sup_state_t`;
  - default parameter constants;
  - the `unlock_count` width constant.
- One sub-module, `sync_2ff`: a generic 2-flop bit synchroniser with an async active-low reset to 0. Other clock-domain crossings in the design reuse it.

## Test plan
All scenarios use PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2.
- **Nominal:** `locked` rises 20 cycles after reset release -> `pll_rst` high for 4 cycles; `sys_rst_n` and `lock_ok` rise 3+8 cycles after `locked`; `retry_count`=0.
- **Timeout then recovery:** `locked` held 0 -> `retry_count`=1 and a new 4-cycle `pll_rst` pulse after 100 WAIT_LOCK cycles. Raise `locked` during the 2nd attempt -> RUN.
- **Fault:** `locked` never rises -> after 2 timeouts `fault`=1, `pll_rst`=1, `retry_count`=2. Then pulse `restart` -> `fault`=0, `retry_count`=0, `pll_rst` pulse restarts.
- **Glitch in STABILIZE:** drop `locked` for 1 cycle at STABILIZE cycle 5 -> return to WAIT_LOCK, no release; release happens 8 cycles after re-lock.
- **Lock loss in RUN:** drop `locked` -> `sys_rst_n`=0 3 edges later, `unlock_count` 0->1. Repeat 300 times -> `unlock_count` saturates at 255.
- **Async reset mid-STABILIZE, and `restart` coinciding with a RUN lock loss:** reset mid-STABILIZE -> all outputs at reset values immediately. `restart` on the same cycle as a RUN lock loss -> `unlock_count` unchanged.

Source files
------------

// File: rtl/video_ctrl_pkg.sv
// Shared types and default constants for the video control slice:
// PLL supervisor state encoding, timing defaults and counter widths.
package video_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_RESET_PLL = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABILIZE = 3'd2,
        ST_RUN       = 3'd3,
        ST_FAULT     = 3'd4
    } pll_sup_state_t;

    localparam int DEF_PLL_RST_CYCLES = 16;
    localparam int DEF_LOCK_TIMEOUT   = 50000;
    localparam int DEF_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES    = 3;

    localparam int UNLOCK_CNT_W = 8;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop single-bit synchroniser; both flops reset to 0.
module sync_2ff (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic meta_p0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/pll_lock_supervisor.sv
// Sequences the pixel PLL reset, qualifies lock as stable, releases the video
// domain reset, and re-sequences on lock loss with a bounded retry budget.
module pll_lock_supervisor
    import video_ctrl_pkg::*;
#(
    parameter int PLL_RST_CYCLES = DEF_PLL_RST_CYCLES,
    parameter int LOCK_TIMEOUT   = DEF_LOCK_TIMEOUT,
    parameter int STABLE_CYCLES  = DEF_STABLE_CYCLES,
    parameter int MAX_RETRIES    = DEF_MAX_RETRIES
) (
    input  logic                    refclk,
    input  logic                    rst_n,
    input  logic                    locked,
    input  logic                    restart,
    output logic                    pll_rst,
    output logic                    sys_rst_n,
    output logic                    lock_ok,
    output logic                    fault,
    output logic [2:0]              retry_count,
    output logic [UNLOCK_CNT_W-1:0] unlock_count
);

    localparam int TMR_MAX = max_int(max_int(PLL_RST_CYCLES, LOCK_TIMEOUT),
                                     max_int(STABLE_CYCLES, MAX_RETRIES));
    localparam int TMR_W   = $clog2(TMR_MAX) + 1;

    localparam logic [TMR_W-1:0] RST_LAST    = TMR_W'(PLL_RST_CYCLES - 1);
    localparam logic [TMR_W-1:0] LOCK_LAST   = TMR_W'(LOCK_TIMEOUT - 1);
    localparam logic [TMR_W-1:0] STABLE_LAST = TMR_W'(STABLE_CYCLES - 1);
    localparam logic [2:0]       RETRY_LIMIT = 3'(MAX_RETRIES);

    function automatic logic [UNLOCK_CNT_W-1:0] sat_inc(input logic [UNLOCK_CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

    logic                    locked_s;
    pll_sup_state_t          state, state_nxt;
    logic [TMR_W-1:0]        timer;
    logic                    timer_clr;
    logic [2:0]              retry_nxt;
    logic [UNLOCK_CNT_W-1:0] unlock_nxt;

    sync_2ff u_locked_sync (
        .clk   (refclk),
        .rst_n (rst_n),
        .d     (locked),
        .q     (locked_s)
    );

    always_comb begin
        state_nxt  = state;
        retry_nxt  = retry_count;
        unlock_nxt = unlock_count;

        if (restart) begin
            // restart wins over everything, including a concurrent lock loss
            state_nxt = ST_RESET_PLL;
            retry_nxt = 3'd0;
        end else begin
            unique case (state)
                ST_RESET_PLL: if (timer == RST_LAST) state_nxt = ST_WAIT_LOCK;
                ST_WAIT_LOCK: begin
                    if (locked_s) begin
                        state_nxt = ST_STABILIZE;
                    end else if (timer == LOCK_LAST) begin
                        retry_nxt = retry_count + 3'd1;
                        state_nxt = (retry_nxt == RETRY_LIMIT) ? ST_FAULT : ST_RESET_PLL;
                    end
                end
                ST_STABILIZE: begin
                    if (!locked_s)                 state_nxt = ST_WAIT_LOCK;
                    else if (timer == STABLE_LAST) state_nxt = ST_RUN;
                end
                ST_RUN: begin
                    if (!locked_s) begin
                        unlock_nxt = sat_inc(unlock_count);
                        retry_nxt  = 3'd0;
                        state_nxt  = ST_RESET_PLL;
                    end
                end
                ST_FAULT: state_nxt = ST_FAULT;
                default:  state_nxt = ST_RESET_PLL;
            endcase
        end

        timer_clr = restart || (state_nxt != state);
    end

    // Outputs are decoded from the next state so they align with the state register.
    always_ff @(posedge refclk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= ST_RESET_PLL;
            timer        <= '0;
            retry_count  <= 3'd0;
            unlock_count <= '0;
            pll_rst      <= 1'b1;
            sys_rst_n    <= 1'b0;
            lock_ok      <= 1'b0;
            fault        <= 1'b0;
        end else begin
            state        <= state_nxt;
            timer        <= timer_clr ? '0 : timer + 1'b1;
            retry_count  <= retry_nxt;
            unlock_count <= unlock_nxt;
            pll_rst      <= (state_nxt == ST_RESET_PLL) || (state_nxt == ST_FAULT);
            sys_rst_n    <= (state_nxt == ST_RUN);
            lock_ok      <= (state_nxt == ST_RUN);
            fault        <= (state_nxt == ST_FAULT);
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Directed bench for pll_lock_supervisor with shortened timing parameters
// (PLL_RST_CYCLES=4, LOCK_TIMEOUT=100, STABLE_CYCLES=8, MAX_RETRIES=2).
module tb_pll_lock_supervisor;

    logic       refclk;
    logic       rst_n;
    logic       locked;
    logic       restart;
    logic       pll_rst;
    logic       sys_rst_n;
    logic       lock_ok;
    logic       fault;
    logic [2:0] retry_count;
    logic [7:0] unlock_count;

    int tests = 0;
    int fails = 0;

    pll_lock_supervisor #(
        .PLL_RST_CYCLES (4),
        .LOCK_TIMEOUT   (100),
        .STABLE_CYCLES  (8),
        .MAX_RETRIES    (2)
    ) dut (
        .refclk       (refclk),
        .rst_n        (rst_n),
        .locked       (locked),
        .restart      (restart),
        .pll_rst      (pll_rst),
        .sys_rst_n    (sys_rst_n),
        .lock_ok      (lock_ok),
        .fault        (fault),
        .retry_count  (retry_count),
        .unlock_count (unlock_count)
    );

    initial begin
        refclk = 1'b0;
        forever #5 refclk = ~refclk;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, tests=%0d failed=%0d", tests, fails);
        $fatal(1, "watchdog expired");
    end

    // Advance n rising edges, then settle 1 ns past the last one.
    task automatic tick(input int n);
        repeat (n) @(posedge refclk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n   = 1'b0;
        locked  = 1'b0;
        restart = 1'b0;
        tick(3);
        chk("reset_pll_rst",   pll_rst,      8'd1);
        chk("reset_sys_rst_n", sys_rst_n,    8'd0);
        chk("reset_lock_ok",   lock_ok,      8'd0);
        chk("reset_fault",     fault,        8'd0);
        chk("reset_retry",     retry_count,  8'd0);
        chk("reset_unlock",    unlock_count, 8'd0);

        // Nominal: 4-edge PLL reset pulse, locked rises at edge 20, release at 31
        rst_n = 1'b1;
        tick(3);  chk("nom_pll_rst_e3", pll_rst, 8'd1);
        tick(1);  chk("nom_pll_rst_e4", pll_rst, 8'd0);
        tick(16); locked = 1'b1;
        tick(10); chk("nom_lock_ok_e30", lock_ok, 8'd0);
                  chk("nom_sys_rst_e30", sys_rst_n, 8'd0);
        tick(1);  chk("nom_sys_rst_e31", sys_rst_n, 8'd1);
                  chk("nom_lock_ok_e31", lock_ok, 8'd1);
                  chk("nom_retry",       retry_count, 8'd0);
                  chk("nom_pll_rst_run", pll_rst, 8'd0);

        // Lock loss in RUN: reset reaches the video domain 3 edges later
        locked = 1'b0;
        tick(2);  chk("loss_sys_rst_e2", sys_rst_n, 8'd1);
                  chk("loss_unlock_e2",  unlock_count, 8'd0);
        tick(1);  chk("loss_sys_rst_e3", sys_rst_n, 8'd0);
                  chk("loss_pll_rst_e3", pll_rst, 8'd1);
                  chk("loss_unlock_e3",  unlock_count, 8'd1);
        locked = 1'b1;
        tick(13); chk("loss_relock_run", lock_ok, 8'd1);

        // restart sampled on the same edge the lock loss reaches the FSM
        locked = 1'b0;
        tick(2);  restart = 1'b1;
        tick(1);  restart = 1'b0;
                  chk("rst_loss_unlock",  unlock_count, 8'd1);
                  chk("rst_loss_pll_rst", pll_rst, 8'd1);
                  chk("rst_loss_sys_rst", sys_rst_n, 8'd0);
        locked = 1'b1;
        tick(13); chk("rst_loss_relock", lock_ok, 8'd1);

        // 299 further losses: counter reaches 254 at i=252, then saturates
        for (int i = 0; i < 299; i++) begin
            locked = 1'b0;
            tick(3);
            locked = 1'b1;
            tick(13);
            if (i == 252) chk("sat_unlock_254", unlock_count, 8'd254);
        end
        chk("sat_unlock_255", unlock_count, 8'd255);
        chk("sat_lock_ok",    lock_ok, 8'd1);

        // Glitch at STABILIZE cycle 5 (entry edge E = 8 edges after drop)
        locked = 1'b0;
        tick(3);  locked = 1'b1;
        tick(5);
        tick(4);  locked = 1'b0;
        tick(1);  locked = 1'b1;
        tick(3);  chk("glitch_no_release_e8",  lock_ok, 8'd0);
        tick(7);  chk("glitch_no_release_e15", lock_ok, 8'd0);
        tick(1);  chk("glitch_release_e16",    lock_ok, 8'd1);
                  chk("glitch_sys_rst_e16",    sys_rst_n, 8'd1);

        // Timeout then recovery on the 2nd attempt
        locked = 1'b0;
        tick(3);
        tick(4);  chk("to_wait_pll_rst", pll_rst, 8'd0);
        tick(99); chk("to_pre_pll_rst",  pll_rst, 8'd0);
                  chk("to_pre_retry",    retry_count, 8'd0);
        tick(1);  chk("to_pll_rst",      pll_rst, 8'd1);
                  chk("to_retry",        retry_count, 8'd1);
        tick(3);  chk("to_pulse_e3",     pll_rst, 8'd1);
        tick(1);  chk("to_pulse_e4",     pll_rst, 8'd0);
        tick(10); locked = 1'b1;
        tick(10); chk("to_rec_pre",      lock_ok, 8'd0);
        tick(1);  chk("to_rec_run",      lock_ok, 8'd1);
                  chk("to_rec_retry",    retry_count, 8'd1);

        // Fault after two timeouts
        locked = 1'b0;
        tick(3);   chk("flt_retry_clr", retry_count, 8'd0);
        tick(4);
        tick(100); chk("flt_retry_1",   retry_count, 8'd1);
        tick(103); chk("flt_pre_fault", fault, 8'd0);
        tick(1);   chk("flt_fault",     fault, 8'd1);
                   chk("flt_pll_rst",   pll_rst, 8'd1);
                   chk("flt_retry_2",   retry_count, 8'd2);
                   chk("flt_sys_rst",   sys_rst_n, 8'd0);
        tick(5);   chk("flt_hold",      fault, 8'd1);

        // restart leaves FAULT and starts a fresh 4-edge pulse
        restart = 1'b1;
        tick(1);  restart = 1'b0;
                  chk("rs_fault",   fault, 8'd0);
                  chk("rs_retry",   retry_count, 8'd0);
                  chk("rs_pll_rst", pll_rst, 8'd1);
        tick(3);  chk("rs_pulse_e4", pll_rst, 8'd1);
        tick(1);  chk("rs_pulse_e5", pll_rst, 8'd0);

        // Async reset mid-STABILIZE takes effect between clock edges
        locked = 1'b1;
        tick(3);
        tick(3);  chk("ar_pre_pll_rst", pll_rst, 8'd0);
                  chk("ar_pre_unlock",  unlock_count, 8'd255);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_pll_rst", pll_rst, 8'd1);
        chk("ar_sys_rst", sys_rst_n, 8'd0);
        chk("ar_lock_ok", lock_ok, 8'd0);
        chk("ar_fault",   fault, 8'd0);
        chk("ar_retry",   retry_count, 8'd0);
        chk("ar_unlock",  unlock_count, 8'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
